sample_uart_framer: RTL and testbench

- Consumes the four calibrated (or raw ADC) sample channels plus the codec `sample_clk` strobe.
- Snapshots one 4-channel sample set and serialises it as a fixed 10-byte framed packet on a UART TX pin for host-side capture and calibration tooling.
- Sits downstream of the codec/calibration stage, alongside the DSP core, and drives the board TX pin.
- Frames that arrive while a packet is in flight are dropped and counted, not queued.

---
 rtl/sample_uart_framer_pkg.sv | 13 +
 rtl/sample_uart_framer_uart_tx_byte.sv | 55 +++++
 rtl/sample_uart_framer.sv | 112 +++++++++++
 tb/tb_sample_uart_framer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_uart_framer_pkg.sv
// Shared constants and FSM state type for the sample UART framer.
// Packet = 2 sync bytes + 4 big-endian 16-bit samples, 8N1 framing.
package sample_uart_pkg;
  localparam logic [7:0] HDR0_DEF      = 8'hBE;
  localparam logic [7:0] HDR1_DEF      = 8'hEF;
  localparam int         FRAME_BYTES   = 10;
  localparam int         BITS_PER_BYTE = 10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/sample_uart_framer_uart_tx_byte.sv
// 8N1 byte serialiser, DIV cycles per bit; tx lags acceptance by one cycle.
// Backpressure: byte_rdy only when idle or in the final stop-bit cycle, so bytes chain gap-free.
module uart_tx_byte
  import sample_uart_pkg::*;
#(
  parameter int DIV = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_vld,
  input  logic [7:0] byte_dat,
  output logic       byte_rdy,
  output logic       tx,
  output logic       last_cycle
);
  localparam int CW = $clog2(DIV);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    shreg;
  logic          bit_end;

  assign bit_end    = (baud_cnt == CW'(DIV - 1));
  assign last_cycle = active && bit_end && (bit_idx == 4'(BITS_PER_BYTE - 1));
  assign byte_rdy   = !active || last_cycle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
      tx       <= 1'b1;
    end else begin
      // Registered pin: shows the bit currently being timed by the counters.
      tx <= active ? shreg[0] : 1'b1;
      if (byte_vld && byte_rdy) begin
        active   <= 1'b1;
        baud_cnt <= '0;
        bit_idx  <= '0;
        shreg    <= {1'b1, byte_dat, 1'b0};
      end else if (active) begin
        if (bit_end) begin
          baud_cnt <= '0;
          bit_idx  <= bit_idx + 4'd1;
          shreg    <= {1'b1, shreg[9:1]};
          if (last_cycle) active <= 1'b0;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/sample_uart_framer.sv
// Snapshots in0..in3 on a sample_clk rising edge and sends a 10-byte UART packet; tx start bit 2 cycles after edge.
// No backpressure: edges arriving while a packet is in flight are dropped and counted (saturating).
module sample_uart_framer
  import sample_uart_pkg::*;
#(
  parameter int         W      = 16,
  parameter int         CLK_HZ = 12000000,
  parameter int         BAUD   = 1000000,
  parameter logic [7:0] HDR0   = HDR0_DEF,
  parameter logic [7:0] HDR1   = HDR1_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_clk,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic         tx_o,
  output logic         busy,
  output logic [7:0]   drop_count
);
  localparam int DIV = CLK_HZ / BAUD;

  if (W != 16) begin : g_bad_w
    $error("sample_uart_framer: W must be 16");
  end
  if ((CLK_HZ % BAUD) != 0 || DIV < 4) begin : g_bad_div
    $error("sample_uart_framer: CLK_HZ/BAUD must be an integer >= 4");
  end

  state_t       state, state_nxt;
  logic         sc_q;
  logic         smp_edge;
  logic [W-1:0] sh0, sh1, sh2, sh3;
  logic [3:0]   byte_idx;
  logic         byte_vld, byte_rdy, last_cycle;
  logic [7:0]   byte_dat;
  logic         pkt_done;

  assign smp_edge = sample_clk & ~sc_q;
  // byte_idx has already moved past the last byte when its stop bit ends.
  assign pkt_done = last_cycle && (byte_idx == 4'(FRAME_BYTES));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (smp_edge) state_nxt = SEND;
      SEND:    if (pkt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_vld = (state == SEND) && (byte_idx < 4'(FRAME_BYTES));
    byte_dat = HDR0;
    case (byte_idx)
      4'd1:    byte_dat = HDR1;
      4'd2:    byte_dat = sh0[15:8];
      4'd3:    byte_dat = sh0[7:0];
      4'd4:    byte_dat = sh1[15:8];
      4'd5:    byte_dat = sh1[7:0];
      4'd6:    byte_dat = sh2[15:8];
      4'd7:    byte_dat = sh2[7:0];
      4'd8:    byte_dat = sh3[15:8];
      4'd9:    byte_dat = sh3[7:0];
      default: byte_dat = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_q       <= 1'b0;
      busy       <= 1'b0;
      drop_count <= 8'd0;
      byte_idx   <= 4'd0;
    end else begin
      sc_q <= sample_clk;
      busy <= (state == SEND) && !pkt_done;
      if (smp_edge && (state != IDLE) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      if (state == IDLE)
        byte_idx <= 4'd0;
      else if (byte_vld && byte_rdy)
        byte_idx <= byte_idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && smp_edge) begin
      sh0 <= in0;
      sh1 <= in1;
      sh2 <= in2;
      sh3 <= in3;
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_vld  (byte_vld),
    .byte_dat  (byte_dat),
    .byte_rdy  (byte_rdy),
    .tx        (tx_o),
    .last_cycle(last_cycle)
  );
endmodule

// File: tb/tb_sample_uart_framer.sv
// Randomised bench: packet-level reference model feeds a scoreboard queue; a negedge monitor decodes tx_o.
module tb_sample_uart_framer;
  localparam int DIV  = 12;
  localparam int PKT  = 100 * DIV;
  localparam int MAXC = 40000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_clk = 1'b0;
  logic [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic        tx_o, busy;
  logic [7:0]  drop_count;

  sample_uart_framer #(
    .W(16), .CLK_HZ(12000000), .BAUD(1000000), .HDR0(8'hBE), .HDR1(8'hEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .tx_o(tx_o), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          start;
    logic [79:0] bytes;
  } pkt_t;
  pkt_t exp_q[$];

  // Per-edge expectations: index k = value after the k-th rising clk edge.
  bit [7:0] exp_drop [MAXC];
  bit       exp_busy [MAXC];
  bit       exp_valid[MAXC];
  bit       rst_at   [MAXC];

  // Reference model state.
  int acc_cyc = -100000;
  bit m_sc    = 1'b0;
  int m_drop  = 0;
  bit rand_in = 1'b1;

  // Drive inputs for the next clk edge k, advance the model for that edge, then let the edge happen.
  task automatic step(input bit sc, input bit rn);
    int k;
    k = cyc + 1;
    sample_clk = sc;
    rst_n      = rn;
    if (rand_in) begin
      in0 = 16'($urandom);
      in1 = 16'($urandom);
      in2 = 16'($urandom);
      in3 = 16'($urandom);
    end
    if (!rn) begin
      m_sc    = 1'b0;
      m_drop  = 0;
      acc_cyc = -100000;
      exp_q.delete();
    end else begin
      if (sc && !m_sc) begin
        // Free once the previous packet's final cycle has passed.
        if (k - acc_cyc >= PKT + 2) begin
          pkt_t p;
          acc_cyc = k;
          p.start = k + 2;
          p.bytes = {8'hBE, 8'hEF, in0, in1, in2, in3};
          exp_q.push_back(p);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      m_sc = sc;
    end
    if (k < MAXC) begin
      exp_drop[k]  = 8'(m_drop);
      exp_busy[k]  = rn && (k > acc_cyc) && (k <= acc_cyc + PKT);
      exp_valid[k] = 1'b1;
      rst_at[k]    = !rn;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard.
  bit          in_frame = 1'b0;
  bit          ghost = 1'b0;
  int          fstart = 0;
  int          bad = 0;
  logic [7:0]  dec = '0;
  pkt_t        cur;

  always @(negedge clk) begin
    int pos, bidx, byt, bit_n;
    logic expbit;
    logic [7:0] expbyte;
    if (cyc < MAXC && exp_valid[cyc]) begin
      chk($sformatf("busy@%0d", cyc), busy, exp_busy[cyc]);
      chk($sformatf("drop_count@%0d", cyc), drop_count, exp_drop[cyc]);
    end
    if (cyc < MAXC && rst_at[cyc]) begin
      in_frame = 1'b0;
      chk("tx_after_reset", tx_o, 1);
    end else begin
      if (!in_frame && tx_o == 1'b0) begin
        in_frame = 1'b1;
        fstart   = cyc;
        bad      = 0;
        if (exp_q.size() == 0) begin
          ghost = 1'b1;
          chk("unexpected_start", 1, 0);
        end else begin
          ghost = 1'b0;
          cur = exp_q.pop_front();
          chk("start_latency", cyc, cur.start);
        end
      end
      if (in_frame) begin
        pos   = cyc - fstart;
        bidx  = pos / DIV;
        byt   = bidx / 10;
        bit_n = bidx % 10;
        expbyte = cur.bytes[79 - 8*byt -: 8];
        expbit  = (bit_n == 0) ? 1'b0 : (bit_n == 9) ? 1'b1 : expbyte[bit_n - 1];
        if (tx_o !== expbit) bad++;
        if (bit_n >= 1 && bit_n <= 8 && (pos % DIV) == DIV / 2) dec[bit_n - 1] = tx_o;
        if ((pos % DIV) == DIV - 1) begin
          if (!ghost) chk($sformatf("bit_timing b%0d.%0d bad_samples", byt, bit_n), bad, 0);
          if (!ghost && bit_n == 9) chk($sformatf("byte%0d", byt), dec, expbyte);
          bad = 0;
        end
        if (pos == PKT - 1) in_frame = 1'b0;
      end
    end
  end

  initial begin
    bit sc;
    rand_in = 1'b1;
    repeat (3) step(0, 0);
    repeat (2000) step(0, 1);

    // Directed packet, then inputs keep changing every cycle.
    rand_in = 1'b0;
    in0 = 16'h1234; in1 = 16'hFFFF; in2 = 16'h0000; in3 = 16'h8000;
    step(1, 1);
    rand_in = 1'b1;
    repeat (1300) step(0, 1);

    // Random-valued packet with sample_clk held high a few cycles.
    repeat (5) step(1, 1);
    repeat (1300) step(0, 1);

    // 48 kHz strobe: 15 edges, 250 cycles apart.
    repeat (15) begin
      repeat (8) step(1, 1);
      repeat (242) step(0, 1);
    end
    repeat (1300) step(0, 1);

    // Reset 600 cycles into a packet, then a fresh packet.
    step(1, 1);
    repeat (599) step(0, 1);
    step(0, 0);
    repeat (20) step(0, 1);
    step(1, 1);
    repeat (1300) step(0, 1);

    // Random strobe activity.
    sc = 1'b0;
    repeat (4000) begin
      if ($urandom_range(0, 99) < 3) sc = ~sc;
      step(sc, 1);
    end
    repeat (1300) step(0, 1);

    // Long hold gives one packet; fast toggling then saturates the drop counter.
    repeat (5000) step(1, 1);
    repeat (320) begin
      step(0, 1); step(0, 1); step(1, 1); step(1, 1);
    end
    repeat (1300) step(0, 1);

    @(negedge clk);
    #1;
    chk("drop_saturated", drop_count, 8'hFF);
    chk("pending_packets", exp_q.size(), 0);
    chk("frame_open_at_end", in_frame, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
